// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP transmit path.
// Holds the frame width default, the bit-counter width and the FSM state type.
package ssp_pkg;

    // Width of the bit counter needed to index a frame of w bits.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned SSP_DATA_W = 8;
    localparam int unsigned SSP_CNT_W  = cnt_width(SSP_DATA_W);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSync  = 2'd1,
        StShift = 2'd2
    } ssp_state_e;

endpackage

// File: rtl/ssp_clkgen.sv
// PCLK/2 divider for the SSP serial clock.
// Ports:
//   pclk      - system clock
//   clear_b   - asynchronous active-low reset
//   sspclkout - free-running serial clock, 0 in reset
//   rise      - high during the PCLK cycle whose closing posedge drives sspclkout 0->1
module ssp_clkgen (
    input  logic pclk,
    input  logic clear_b,
    output logic sspclkout,
    output logic rise
);

    logic clk_q;

    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= ~clk_q;
        end
    end

    assign sspclkout = clk_q;
    // The next posedge is a rise edge exactly when the divided clock is currently low.
    assign rise      = ~clk_q;

endmodule

// File: rtl/ssp_tx_logic.sv
// SSP (Motorola-style frame) transmit logic.
// Pulls words from a transmit FIFO and shifts them out MSB first on SSPTXD, with a
// one-period frame sync on SSPFSSOUT. Back-to-back words are sent without gaps; the
// sync pulse for a following word overlaps the LSB of the current one.
// Ports:
//   PCLK      - system clock
//   CLEAR_B   - asynchronous active-low reset
//   TX_DATA   - head word of the transmit FIFO
//   TX_EMPTY  - transmit FIFO empty flag
//   TX_POP    - one-PCLK pop strobe to the FIFO
//   SSPCLKOUT - serial clock (PCLK/2)
//   SSPFSSOUT - frame sync
//   SSPTXD    - serial data
//   SSPOE_B   - active-low output enable for SSPTXD
//   TX_BUSY   - transmitter not idle
module ssp_tx_logic
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_W = SSP_DATA_W
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_EMPTY,
    output logic              TX_POP,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    output logic              TX_BUSY
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(DATA_W - 1);

    ssp_state_e        state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fss_q;
    logic              txd_q;
    logic              oe_b_q;
    logic              pop_q;
    logic              rise;

    ssp_clkgen u_clkgen (
        .pclk      (PCLK),
        .clear_b   (CLEAR_B),
        .sspclkout (SSPCLKOUT),
        .rise      (rise)
    );

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            fss_q   <= 1'b0;
            txd_q   <= 1'b0;
            oe_b_q  <= 1'b1;
            pop_q   <= 1'b0;
        end else begin
            // Pop strobe lasts one PCLK: it is cleared on the non-rise edge that follows.
            pop_q <= 1'b0;
            if (rise) begin
                unique case (state_q)
                    StIdle: begin
                        txd_q <= 1'b0;
                        if (!TX_EMPTY) begin
                            shift_q <= TX_DATA;
                            pop_q   <= 1'b1;
                            fss_q   <= 1'b1;
                            oe_b_q  <= 1'b0;
                            state_q <= StSync;
                        end else begin
                            fss_q  <= 1'b0;
                            oe_b_q <= 1'b1;
                        end
                    end
                    StSync: begin
                        fss_q   <= 1'b0;
                        txd_q   <= shift_q[DATA_W-1];
                        cnt_q   <= CNT_MSB;
                        state_q <= StShift;
                    end
                    StShift: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                            txd_q <= shift_q[cnt_q - 1'b1];
                            // Bit-0 edge: shift_q[0] is already captured into txd_q above,
                            // so the next word can be loaded in the same edge.
                            if (cnt_q == CNT_W'(1) && !TX_EMPTY) begin
                                shift_q <= TX_DATA;
                                pop_q   <= 1'b1;
                                fss_q   <= 1'b1;
                            end
                        end else if (fss_q) begin
                            // A word was loaded on the bit-0 edge: go straight to its MSB.
                            fss_q <= 1'b0;
                            txd_q <= shift_q[DATA_W-1];
                            cnt_q <= CNT_MSB;
                        end else begin
                            txd_q   <= 1'b0;
                            oe_b_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign TX_POP    = pop_q;
    assign SSPFSSOUT = fss_q;
    assign SSPTXD    = txd_q;
    assign SSPOE_B   = oe_b_q;
    assign TX_BUSY   = (state_q != StIdle);

endmodule

// File: tb/tb_ssp_tx_logic.sv
// Directed bench for ssp_tx_logic: a FIFO model feeds words, a scoreboard queue holds
// the words expected on the serial line, and a bit monitor reassembles frames.
module tb_ssp_tx_logic;

    localparam int unsigned DATA_W = 8;

    logic              PCLK;
    logic              CLEAR_B;
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_EMPTY;
    logic              TX_POP;
    logic              SSPCLKOUT;
    logic              SSPFSSOUT;
    logic              SSPTXD;
    logic              SSPOE_B;
    logic              TX_BUSY;

    ssp_tx_logic #(
        .DATA_W (DATA_W)
    ) dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .TX_DATA   (TX_DATA),
        .TX_EMPTY  (TX_EMPTY),
        .TX_POP    (TX_POP),
        .SSPCLKOUT (SSPCLKOUT),
        .SSPFSSOUT (SSPFSSOUT),
        .SSPTXD    (SSPTXD),
        .SSPOE_B   (SSPOE_B),
        .TX_BUSY   (TX_BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic [DATA_W-1:0] fifo [$];
    logic [DATA_W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fails  = 0;
    int nbits    = 0;
    int rise_cnt = 0;
    int pop_cnt  = 0;
    int fss_cnt  = 0;
    int oe_low_cnt = 0;
    logic [DATA_W-1:0] word = '0;
    logic prev_fss  = 1'b0;
    logic prev_clk  = 1'b0;
    logic clk_valid = 1'b0;
    logic fss_seen  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        TX_EMPTY = (fifo.size() == 0);
        if (fifo.size() != 0) TX_DATA = fifo[0];
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo.push_back(w);
        exp_q.push_back(w);
        drive();
    endtask

    // One PCLK cycle; everything is sampled at the negedge, away from the active edge.
    task automatic step();
        logic        exp_clk;
        logic [31:0] expw;
        @(negedge PCLK);
        if (!CLEAR_B) begin
            nbits    = 0;
            prev_fss = 1'b0;
        end else begin
            exp_clk = ~prev_clk;
            if (clk_valid) check("sspclk_toggle", {31'b0, SSPCLKOUT}, {31'b0, exp_clk});
            if (SSPCLKOUT) begin
                // SSPCLKOUT high here means the preceding posedge was a rise edge.
                rise_cnt++;
                if (!SSPOE_B) oe_low_cnt++;
                if (nbits > 0) begin
                    check("oe_during_frame", {31'b0, SSPOE_B}, 32'd0);
                    word = {word[DATA_W-2:0], SSPTXD};
                    nbits--;
                    if (nbits == 0) begin
                        if (exp_q.size() != 0) expw = {24'b0, exp_q.pop_front()};
                        else expw = 'x;
                        check("rx_word", {24'b0, word}, expw);
                    end
                end
                if (SSPFSSOUT) begin
                    fss_cnt++;
                    fss_seen = 1'b1;
                    check("fss_single_period", {31'b0, prev_fss}, 32'd0);
                    nbits = DATA_W;
                end
                prev_fss = SSPFSSOUT;
            end
            if (TX_POP) begin
                check("pop_not_empty", {31'b0, TX_EMPTY}, 32'd0);
                pop_cnt++;
                if (fifo.size() != 0) void'(fifo.pop_front());
                drive();
            end
        end
        prev_clk  = SSPCLKOUT;
        clk_valid = 1'b1;
    endtask

    task automatic wait_rises(input int n);
        int target;
        int guard;
        target = rise_cnt + n;
        guard  = 0;
        while (rise_cnt < target && guard < 4 * n + 8) begin
            step();
            guard++;
        end
        check("wait_rises_timeout", {31'b0, rise_cnt >= target}, 32'd1);
    endtask

    task automatic wait_fss();
        int guard;
        fss_seen = 1'b0;
        guard    = 0;
        while (!fss_seen && guard < 200) begin
            step();
            guard++;
        end
        check("wait_fss_timeout", {31'b0, fss_seen}, 32'd1);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        step();
        while ((exp_q.size() != 0 || fifo.size() != 0 || TX_BUSY) && guard < 3000) begin
            step();
            guard++;
        end
        check("wait_idle_timeout", {31'b0, guard < 3000}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sspclk"}, {31'b0, SSPCLKOUT}, 32'd0);
        check({tag, "_fss"},    {31'b0, SSPFSSOUT}, 32'd0);
        check({tag, "_txd"},    {31'b0, SSPTXD},    32'd0);
        check({tag, "_oe_b"},   {31'b0, SSPOE_B},   32'd1);
        check({tag, "_pop"},    {31'b0, TX_POP},    32'd0);
        check({tag, "_busy"},   {31'b0, TX_BUSY},   32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] burst [8];
        int pops0;
        int fss0;
        burst = '{8'h94, 8'h0F, 8'h51, 8'h24, 8'h67, 8'hF3, 8'hB6, 8'h84};

        CLEAR_B  = 1'b0;
        TX_EMPTY = 1'b1;
        TX_DATA  = '0;
        repeat (3) step();
        #1;
        check_reset_outputs("reset");
        CLEAR_B = 1'b1;

        // Single word, then empty FIFO.
        step();
        push(8'h35);
        wait_idle();
        check("single_pops", pop_cnt, 32'd1);
        check("single_oe_b_back", {31'b0, SSPOE_B}, 32'd1);
        check("single_fss_count", fss_cnt, 32'd1);

        // Idle with an empty FIFO for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_fss",  {31'b0, SSPFSSOUT}, 32'd0);
            check("idle_oe_b", {31'b0, SSPOE_B},   32'd1);
            check("idle_pop",  {31'b0, TX_POP},    32'd0);
        end

        // Eight queued words back to back.
        pops0      = pop_cnt;
        fss0       = fss_cnt;
        oe_low_cnt = 0;
        for (int i = 0; i < 8; i++) push(burst[i]);
        wait_idle();
        check("burst_pops", pop_cnt - pops0, 32'd8);
        check("burst_fss_count", fss_cnt - fss0, 32'd8);
        // One sync period plus every bit of every word, with no gaps.
        check("burst_oe_low_periods", oe_low_cnt, 32'(1 + 8 * DATA_W));

        // FIFO refills one PCLK after bit 0 is driven: frame ends, restart from idle.
        repeat (4) step();
        push(8'hAE);
        wait_fss();
        wait_rises(DATA_W);
        step();
        push(8'h5C);
        wait_rises(1);
        check("late_end_oe_b", {31'b0, SSPOE_B},   32'd1);
        check("late_end_busy", {31'b0, TX_BUSY},   32'd0);
        check("late_end_fss",  {31'b0, SSPFSSOUT}, 32'd0);
        wait_rises(1);
        check("late_sync_fss",  {31'b0, SSPFSSOUT}, 32'd1);
        check("late_sync_oe_b", {31'b0, SSPOE_B},   32'd0);
        wait_idle();

        // Reset in the middle of 0xFF (during bit 4); 0x26 follows after release.
        repeat (4) step();
        push(8'hFF);
        wait_fss();
        push(8'h26);
        wait_rises(4);
        pops0   = pop_cnt;
        CLEAR_B = 1'b0;
        #1;
        check_reset_outputs("abort");
        void'(exp_q.pop_front());
        nbits = 0;
        repeat (3) step();
        check("abort_no_pop", pop_cnt - pops0, 32'd0);
        CLEAR_B = 1'b1;
        wait_idle();
        check("abort_pops_after", pop_cnt - pops0, 32'd1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
